// File: rtl/mul32_seq_pkg.sv
// mul32_seq_pkg: shared states, widths, latencies and operand helper for the sequential multiplier
package mul32_seq_pkg;
  localparam int W = 32;
  localparam int CNT_W = 5;
  localparam int MUL_LAT_U = 33;
  localparam int MUL_LAT_S = 35;
  typedef enum logic [2:0] {IDLE, CALC, NEG_LO, NEG_HI, DONE} state_t;
  // magnitude as unsigned; |0x80000000| stays 0x80000000
  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
    return (s && x[W-1]) ? -x : x;
  endfunction
endpackage

// File: rtl/cla32.sv
// cla32: 32-bit carry-lookahead adder, 4-bit lookahead groups
// ports: a, b operands; ci carry in; s sum; c0 carry out
module cla32
  import mul32_seq_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         c0
);
  logic [W-1:0] g, p;
  logic [W:0] c;
  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = ci;
    for (int k = 0; k < W; k += 4) begin
      c[k+1] = g[k] | (p[k] & c[k]);
      c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
      c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k]) | (p[k+2] & p[k+1] & p[k] & c[k]);
      c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1]) | (p[k+3] & p[k+2] & p[k+1] & g[k])
             | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
    end
    s = p ^ c[W-1:0];
    c0 = c[W];
  end
endmodule

// File: rtl/mul32_seq.sv
// mul32_seq: radix-2 shift-add 32x32->64 multiplier, signed/unsigned, built around one cla32
// ports: clk; rst_n async active low; start/sign_mode/a/b launch an op (accepted in IDLE or DONE);
//        busy while computing; done one-cycle pulse; prod held until the next result or reset
module mul32_seq
  import mul32_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           sign_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0] mcand, mplier, hi, lo;
  logic smode, sgn, carry;
  logic [W-1:0] op_a, op_b, sum;
  logic ci, co, accept;
  // the single adder serves accumulation in CALC and two's-complement negation in NEG_LO/NEG_HI
  always_comb begin
    op_a = state == CALC ? hi : state == NEG_LO ? ~lo : state == NEG_HI ? ~hi : '0;
    op_b = (state == CALC && mplier[0]) ? mcand : '0;
    ci = state == NEG_LO ? 1'b1 : state == NEG_HI ? carry : 1'b0;
  end
  cla32 u_cla (.a(op_a), .b(op_b), .ci(ci), .s(sum), .c0(co));
  assign accept = start && (state == IDLE || state == DONE);
  // outputs are registered from the current state, so they trail it by one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      hi <= '0;
      lo <= '0;
      smode <= 1'b0;
      sgn <= 1'b0;
      carry <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      prod <= '0;
    end else begin
      busy <= state == CALC || state == NEG_LO || state == NEG_HI;
      done <= state == DONE;
      if (state == DONE) prod <= {hi, lo};
      if (accept) begin
        state <= CALC;
        cnt <= '0;
        mcand <= mag(a, sign_mode);
        mplier <= mag(b, sign_mode);
        hi <= '0;
        lo <= '0;
        smode <= sign_mode;
        sgn <= sign_mode & (a[W-1] ^ b[W-1]);
        carry <= 1'b0;
      end else
        case (state)
          CALC: begin
            // adder carry becomes the accumulator MSB as the 33-bit sum shifts right
            hi <= {co, sum[W-1:1]};
            lo <= {sum[0], lo[W-1:1]};
            mplier <= mplier >> 1;
            cnt <= cnt + 1'b1;
            if (&cnt) state <= smode ? NEG_LO : DONE;
          end
          NEG_LO: begin
            if (sgn) begin
              lo <= sum;
              carry <= co;
            end
            state <= NEG_HI;
          end
          NEG_HI: begin
            if (sgn) hi <= sum;
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq: directed and randomized self-checking bench for mul32_seq
module tb_mul32_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sign_mode = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [63:0] prod;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mul32_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .sign_mode(sign_mode), .a(a), .b(b),
                 .busy(busy), .done(done), .prod(prod));

  // drives one op from an idle DUT and observes it; entered and left #1 after a rising edge
  task automatic launch(input logic m, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] p, output int lat, output int nbusy, output int ndone, output logic b1);
    sign_mode = m; a = x; b = y; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1; nbusy = 0; ndone = 0; p = '0; b1 = 1'b0;
    for (int k = 1; k <= 45 && !(lat > 0 && k > lat + 1); k++) begin
      @(posedge clk); #1;
      if (k == 1) b1 = busy;
      nbusy += int'(busy);
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = k; p = prod; end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (prod !== 64'h0) begin failures++; $display("FAIL reset_prod: got %h want 0", prod); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    logic        m [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] x [9] = '{32'h77777777, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                           32'h0, 32'h0, 32'hCCCCCCCC, 32'h3};
    logic [31:0] y [9] = '{32'hFFFFFFFF, 32'h2, 32'h2, 32'h80000000, 32'h1, 32'h0, 32'h0, 32'h1, 32'h5};
    logic [63:0] e [9] = '{64'h77777776_88888889, 64'hFFFFFFFF_FFFFFFFE, 64'h00000001_FFFFFFFE,
                           64'h40000000_00000000, 64'hFFFFFFFF_80000000, 64'h0, 64'h0,
                           64'h00000000_CCCCCCCC, 64'd15};
    logic [63:0] p;
    int lat, nb, nd, el;
    logic b1;
    for (int i = 0; i < 9; i++) begin
      el = m[i] ? 35 : 33;
      launch(m[i], x[i], y[i], p, lat, nb, nd, b1);
      checks++; if (p !== e[i]) begin failures++; $display("FAIL vec%0d_prod: got %h want %h", i, p, e[i]); end
      checks++; if (lat != el) begin failures++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, el); end
      checks++; if (nd != 1) begin failures++; $display("FAIL vec%0d_done_pulses: got %0d want 1", i, nd); end
      checks++; if (nb != el - 1 || b1 !== 1'b1) begin failures++; $display("FAIL vec%0d_busy: cycles %0d first %b want %0d first 1", i, nb, b1, el - 1); end
    end
  endtask

  task automatic test_ignore_busy;
    int lat = -1, nd = 0;
    logic [63:0] p = '0;
    sign_mode = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin sign_mode = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1; end
      if (k == 6) start = 1'b0;
      if (done) begin nd++; if (lat < 0) begin lat = k; p = prod; end end
    end
    checks++; if (p !== 64'd15) begin failures++; $display("FAIL ignore_prod: got %h want %h", p, 64'd15); end
    checks++; if (lat != 33) begin failures++; $display("FAIL ignore_latency: got %0d want 33", lat); end
    checks++; if (nd != 1) begin failures++; $display("FAIL ignore_done_pulses: got %0d want 1", nd); end
  endtask

  task automatic test_back_to_back;
    int l1 = -1, l2 = -1, nd = 0;
    logic [63:0] p1 = '0, p2 = '0;
    sign_mode = 1'b0; a = 32'h12345678; b = 32'h10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (k == 32) begin a = 32'hFFFF; b = 32'hFFFF; start = 1'b1; end
      if (k == 33) start = 1'b0;
      if (done) begin
        nd++;
        if (l1 < 0) begin l1 = k; p1 = prod; end else begin l2 = k; p2 = prod; end
      end
    end
    checks++; if (p1 !== 64'h00000001_23456780) begin failures++; $display("FAIL b2b_first_prod: got %h want %h", p1, 64'h00000001_23456780); end
    checks++; if (l1 != 33) begin failures++; $display("FAIL b2b_first_latency: got %0d want 33", l1); end
    checks++; if (p2 !== 64'h00000000_FFFE0001) begin failures++; $display("FAIL b2b_second_prod: got %h want %h", p2, 64'h00000000_FFFE0001); end
    checks++; if (l2 != 66) begin failures++; $display("FAIL b2b_second_latency: got %0d want 66", l2); end
    checks++; if (nd != 2) begin failures++; $display("FAIL b2b_done_pulses: got %0d want 2", nd); end
  endtask

  task automatic test_abort;
    int nd = 0, lat, nb, ndn;
    logic [63:0] p;
    logic b1;
    sign_mode = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b want 0", done); end
    checks++; if (prod !== 64'h0) begin failures++; $display("FAIL abort_prod: got %h want 0", prod); end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      nd += int'(done);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      nd += int'(done);
    end
    checks++; if (nd != 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses want 0", nd); end
    launch(1'b0, 32'd3, 32'd5, p, lat, nb, ndn, b1);
    checks++; if (p !== 64'd15) begin failures++; $display("FAIL abort_rerun_prod: got %h want %h", p, 64'd15); end
    checks++; if (lat != 33) begin failures++; $display("FAIL abort_rerun_latency: got %0d want 33", lat); end
  endtask

  task automatic test_random;
    logic [63:0] p, e;
    logic [31:0] x, y;
    logic m, b1;
    longint sx, sy;
    int lat, nb, nd;
    for (int i = 0; i < 1000; i++) begin
      m = 1'($urandom_range(1));
      x = $urandom;
      y = $urandom;
      if (i % 50 == 0) x = 32'h80000000;
      if (i % 70 == 0) y = 32'hFFFFFFFF;
      if (m) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e = 64'(sx * sy);
      end else e = {32'h0, x} * {32'h0, y};
      launch(m, x, y, p, lat, nb, nd, b1);
      checks++; if (p !== e) begin failures++; $display("FAIL rand%0d_prod: m=%b a=%h b=%h got %h want %h", i, m, x, y, p, e); end
      checks++; if (lat != (m ? 35 : 33) || nd != 1) begin failures++; $display("FAIL rand%0d_timing: latency %0d pulses %0d want %0d and 1", i, lat, nd, m ? 35 : 33); end
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_ignore_busy;
    test_back_to_back;
    test_abort;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
